// File: rtl/fp_adder_arbiter_pkg.sv
// Shared types and constants for the floating-point adder arbiter.
package fp_adder_arbiter_pkg;

   // IEEE-754 single-precision value carried as raw bits
   typedef logic [31:0] float;

   // Sequencer states for one adder operation
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      RESPOND = 2'd3
   } arb_state_t;

   // Cycles after Go before an operation is abandoned
   localparam int FP_ARB_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/fp_adder_arbiter_if.sv
// Bundle of requester-side and adder-side signals around the arbiter.
// slave: the arbiter itself. master: the clients plus the adder.
interface fp_adder_arbiter_if
   import fp_adder_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
);

   // Requester side
   logic [NUM_REQ-1:0]    ReqValid;
   logic [NUM_REQ-1:0]    ReqReady;
   logic [NUM_REQ*32-1:0] ReqA;
   logic [NUM_REQ*32-1:0] ReqB;
   logic [NUM_REQ-1:0]    RespValid;
   float                  RespResult;
   logic                  RespZero;
   logic                  RespInf;
   logic                  RespNan;
   logic                  RespError;
   logic [IDW-1:0]        RespId;

   // Adder side
   float                  AdderA;
   float                  AdderB;
   logic                  AdderGo;
   float                  AdderResult;
   logic                  AdderReady;
   logic                  AdderZero;
   logic                  AdderInf;
   logic                  AdderNan;

   modport slave (
      input  ReqValid, ReqA, ReqB,
      input  AdderResult, AdderReady, AdderZero, AdderInf, AdderNan,
      output ReqReady, RespValid, RespResult, RespZero, RespInf, RespNan,
      output RespError, RespId,
      output AdderA, AdderB, AdderGo
   );

   modport master (
      output ReqValid, ReqA, ReqB,
      output AdderResult, AdderReady, AdderZero, AdderInf, AdderNan,
      input  ReqReady, RespValid, RespResult, RespZero, RespInf, RespNan,
      input  RespError, RespId,
      input  AdderA, AdderB, AdderGo
   );

endinterface

// File: rtl/fp_adder_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first set request found when
// searching upward from i_ptr+1, wrapping modulo NUM_REQ.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDW-1:0]     i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDW-1:0]     o_idx,
   output logic               o_any
);

   // Walk candidates from lowest to highest priority so the winner is written last
   always_comb begin
      // NOTE: every output gets a default before the search; otherwise a path
      // with no match would hold the old value and infer a latch.
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if ((i == (int'(i_ptr) + k) % NUM_REQ) && i_req[i]) begin
               o_grant    = '0;
               o_grant[i] = 1'b1;
               o_idx      = IDW'(i);
               o_any      = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fp_adder_arbiter.sv
// Shares one floating-point adder among NUM_REQ requesters: round-robin
// grant, one operation in flight, result routed back to its owner.
module fp_adder_arbiter
   import fp_adder_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = FP_ARB_TIMEOUT_DEFAULT,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic              Clock,
   input  logic              Reset,
   fp_adder_arbiter_if.slave bus,
   output logic              Busy
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   arb_state_t         r_state;
   logic [IDW-1:0]     r_ptr;
   logic [IDW-1:0]     r_id;
   float               r_op_a;
   float               r_op_b;
   logic               r_go;
   logic               r_ready_d;
   logic [CW-1:0]      r_cnt;
   logic [NUM_REQ-1:0] r_resp_valid;
   float               r_resp_result;
   logic               r_resp_zero;
   logic               r_resp_inf;
   logic               r_resp_nan;
   logic               r_resp_error;
   logic [IDW-1:0]     r_resp_id;

   logic [NUM_REQ-1:0] w_grant;
   logic [IDW-1:0]     w_grant_idx;
   logic               w_any;
   float               w_op_a;
   float               w_op_b;
   logic               w_ready_rise;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_rr (
      .i_req   (bus.ReqValid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_grant_idx),
      .o_any   (w_any)
   );

   // Select the grantee's operand pair from the packed request buses
   always_comb begin
      w_op_a = '0;
      w_op_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_op_a = bus.ReqA[32*i +: 32];
            w_op_b = bus.ReqB[32*i +: 32];
         end
      end
   end

   // A ReadyResult level left over from an earlier op must not complete this one
   assign w_ready_rise = bus.AdderReady & ~r_ready_d;

   assign bus.ReqReady   = (r_state == IDLE) ? w_grant : '0;
   assign bus.AdderA     = r_op_a;
   assign bus.AdderB     = r_op_b;
   assign bus.AdderGo    = r_go;
   assign bus.RespValid  = r_resp_valid;
   assign bus.RespResult = r_resp_result;
   assign bus.RespZero   = r_resp_zero;
   assign bus.RespInf    = r_resp_inf;
   assign bus.RespNan    = r_resp_nan;
   assign bus.RespError  = r_resp_error;
   assign bus.RespId     = r_resp_id;
   assign Busy           = (r_state != IDLE);

   // Operation sequencer: grant, pulse Go, wait for result or timeout, respond
   always_ff @(posedge Clock) begin
      // NOTE: reset is synchronous and active-high here, so it is just the
      // first branch inside the clocked block, not in the sensitivity list.
      if (Reset) begin
         r_state       <= IDLE;
         r_ptr         <= IDW'(NUM_REQ - 1);
         r_id          <= '0;
         r_op_a        <= '0;
         r_op_b        <= '0;
         r_go          <= 1'b0;
         r_ready_d     <= 1'b0;
         r_cnt         <= '0;
         r_resp_valid  <= '0;
         r_resp_result <= '0;
         r_resp_zero   <= 1'b0;
         r_resp_inf    <= 1'b0;
         r_resp_nan    <= 1'b0;
         r_resp_error  <= 1'b0;
         r_resp_id     <= '0;
      end else begin
         // NOTE: all state updates use non-blocking assignment so every
         // register sees the pre-edge value of every other register.
         r_ready_d    <= bus.AdderReady;
         r_go         <= 1'b0;
         r_resp_valid <= '0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_op_a  <= w_op_a;
                  r_op_b  <= w_op_b;
                  r_id    <= w_grant_idx;
                  r_ptr   <= w_grant_idx;
                  r_go    <= 1'b1;
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               r_cnt   <= '0;
               r_state <= WAIT;
            end
            WAIT: begin
               if (w_ready_rise) begin
                  r_resp_result <= bus.AdderResult;
                  r_resp_zero   <= bus.AdderZero;
                  r_resp_inf    <= bus.AdderInf;
                  r_resp_nan    <= bus.AdderNan;
                  r_resp_error  <= 1'b0;
                  r_resp_id     <= r_id;
                  r_op_a        <= '0;
                  r_op_b        <= '0;
                  r_state       <= RESPOND;
               end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                  r_resp_result <= '0;
                  r_resp_zero   <= 1'b0;
                  r_resp_inf    <= 1'b0;
                  r_resp_nan    <= 1'b0;
                  r_resp_error  <= 1'b1;
                  r_resp_id     <= r_id;
                  r_op_a        <= '0;
                  r_op_b        <= '0;
                  r_state       <= RESPOND;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RESPOND: begin
               r_resp_valid <= NUM_REQ'(1) << r_id;
               r_state      <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Directed self-checking bench for fp_adder_arbiter with a behavioural adder
// and a scoreboard of expected responses in issue order.
module tb_fp_adder_arbiter;
   import fp_adder_arbiter_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int TIMEOUT = 64;
   localparam int IDW     = 2;
   localparam int LAT     = 3;

   typedef enum int {M_NORMAL, M_NEVER, M_STUCK} adder_mode_t;

   typedef struct {
      int         id;
      float       result;
      logic [3:0] flags;   // {zero, inf, nan, error}
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic busy;

   fp_adder_arbiter_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus ();

   fp_adder_arbiter #(
      .NUM_REQ (NUM_REQ),
      .TIMEOUT (TIMEOUT),
      .IDW     (IDW)
   ) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus),
      .Busy  (busy)
   );

   always #5 clk = ~clk;

   int          n_checks   = 0;
   int          n_errors   = 0;
   int          cyc        = 0;
   int          go_cyc     = 0;
   int          hs_cyc     = 0;
   int          resp_cyc   = 0;
   int          go_count   = 0;
   int          resp_count = 0;
   int          go_run     = 0;
   float        go_a       = '0;
   logic        go_busy    = 1'b0;
   logic        multi_hot  = 1'b0;
   int          hs_log[$];
   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [NUM_REQ-1:0] drop_mask = '0;
   adder_mode_t mode = M_NORMAL;
   float        la, lb, lr;
   int          lat_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Exact sums for the operand pairs used below
   function automatic float fadd(input float a, input float b);
      case ({a, b})
         {32'h3F800000, 32'h40000000}: return 32'h40400000;
         {32'h3F800000, 32'h3F800000}: return 32'h40000000;
         {32'h40000000, 32'h40000000}: return 32'h40800000;
         {32'h3F800000, 32'hBF800000}: return 32'h00000000;
         {32'h7FC00000, 32'h3F800000}: return 32'h7FC00000;
         {32'h40800000, 32'h40800000}: return 32'h41000000;
         {32'h40000000, 32'h3F800000}: return 32'h40400000;
         {32'h3F000000, 32'h3F000000}: return 32'h3F800000;
         {32'h40400000, 32'h3F800000}: return 32'h40800000;
         default:                      return 32'h12345678;
      endcase
   endfunction

   // Behavioural adder: ResultReady rises LAT cycles after Go, drops on the next Go
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bus.AdderGo) begin
            la      = bus.AdderA;
            lb      = bus.AdderB;
            lat_cnt = LAT;
            if (mode != M_STUCK) bus.AdderReady = 1'b0;
         end else if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0 && mode == M_NORMAL) begin
               lr              = fadd(la, lb);
               bus.AdderResult = lr;
               bus.AdderZero   = (lr[30:0] == 31'd0);
               bus.AdderInf    = (lr[30:23] == 8'hFF) && (lr[22:0] == 23'd0);
               bus.AdderNan    = (lr[30:23] == 8'hFF) && (lr[22:0] != 23'd0);
               bus.AdderReady  = 1'b1;
            end
         end
      end
   end

   // Requesters drop ReqValid right after their handshake edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (drop_mask != '0) begin
            bus.ReqValid = bus.ReqValid & ~drop_mask;
            drop_mask    = '0;
         end
      end
   end

   // Monitor and scoreboard, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.AdderGo) begin
         go_cyc  = cyc;
         go_a    = bus.AdderA;
         go_busy = busy;
         go_count++;
         go_run++;
      end else if (go_run > 0) begin
         check("go_width", go_run, 1);
         go_run = 0;
      end
      if ((bus.ReqReady & (bus.ReqReady - 1'b1)) != '0) multi_hot = 1'b1;
      if (!rst && ((bus.ReqValid & bus.ReqReady) != '0)) begin
         hs_cyc    = cyc;
         drop_mask = bus.ReqValid & bus.ReqReady;
         for (int i = 0; i < NUM_REQ; i++) if (drop_mask[i]) hs_log.push_back(i);
      end
      if (bus.RespValid != '0) begin
         resp_cyc = cyc;
         resp_count++;
         if (exp_q.size() == 0) begin
            check("unexpected_resp", bus.RespValid, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("resp_valid", bus.RespValid, 64'd1 << mon_e.id);
            check("resp_id", bus.RespId, mon_e.id);
            check("resp_result", bus.RespResult, mon_e.result);
            check("resp_flags", {bus.RespZero, bus.RespInf, bus.RespNan, bus.RespError},
                  mon_e.flags);
         end
      end
   end

   task automatic expect_resp(input int id, input float r, input logic [3:0] f);
      exp_t e;
      e.id     = id;
      e.result = r;
      e.flags  = f;
      exp_q.push_back(e);
   endtask

   task automatic set_req(input int id, input float a, input float b);
      bus.ReqA[32*id +: 32] = a;
      bus.ReqB[32*id +: 32] = b;
      bus.ReqValid[id]      = 1'b1;
   endtask

   task automatic wait_hs(input int n);
      for (int i = 0; i < 200 && hs_log.size() < n; i++) @(negedge clk);
      check("hs_count", hs_log.size(), n);
   endtask

   task automatic wait_go(input int n);
      for (int i = 0; i < 200 && go_count < n; i++) @(negedge clk);
      check("go_count", go_count, n);
   endtask

   task automatic wait_resp(input int n, input int budget);
      for (int i = 0; i < budget && resp_count < n; i++) @(negedge clk);
      check("resp_count", resp_count, n);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst             = 1'b1;
      bus.ReqValid    = '0;
      bus.ReqA        = '0;
      bus.ReqB        = '0;
      bus.AdderResult = '0;
      bus.AdderReady  = 1'b0;
      bus.AdderZero   = 1'b0;
      bus.AdderInf    = 1'b0;
      bus.AdderNan    = 1'b0;
      repeat (3) @(posedge clk);

      // Reset state
      @(negedge clk);
      check("rst_resp_valid", bus.RespValid, 0);
      check("rst_adder_go", bus.AdderGo, 0);
      check("rst_adder_ab", {bus.AdderA, bus.AdderB}, 0);
      check("rst_resp_result", bus.RespResult, 0);
      check("rst_resp_flags", {bus.RespZero, bus.RespInf, bus.RespNan, bus.RespError}, 0);
      check("rst_resp_id", bus.RespId, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", bus.ReqReady, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Single op from requester 1: 1.0 + 2.0
      expect_resp(1, 32'h40400000, 4'b0000);
      @(posedge clk);
      #2 set_req(1, 32'h3F800000, 32'h40000000);
      wait_hs(1);
      wait_go(1);
      check("go_after_hs", go_cyc - hs_cyc, 1);
      check("go_operand_a", go_a, 32'h3F800000);
      check("busy_at_go", go_busy, 1);
      wait_resp(1, 40);

      // Reset while waiting on the adder drops the operation
      @(posedge clk);
      #2 set_req(1, 32'h40000000, 32'h40000000);
      wait_go(2);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rstwait_go", bus.AdderGo, 0);
      check("rstwait_busy", busy, 0);
      check("rstwait_resp_valid", bus.RespValid, 0);
      repeat (10) @(negedge clk);
      check("rstwait_no_resp", resp_count, 1);

      // Contention: all four at once, grants 0,1,2,3 after reset
      expect_resp(0, 32'h40000000, 4'b0000);
      expect_resp(1, 32'h40800000, 4'b0000);
      expect_resp(2, 32'h00000000, 4'b1000);
      expect_resp(3, 32'h7FC00000, 4'b0010);
      @(posedge clk);
      #2;
      set_req(0, 32'h3F800000, 32'h3F800000);
      set_req(1, 32'h40000000, 32'h40000000);
      set_req(2, 32'h3F800000, 32'hBF800000);
      set_req(3, 32'h7FC00000, 32'h3F800000);
      wait_resp(5, 200);
      for (int k = 0; k < 4; k++) check("contention_order", hs_log[2+k], k);

      // Fairness: requester 0 re-requests, requester 2 arrives mid-op; 2 goes next
      expect_resp(0, 32'h41000000, 4'b0000);
      expect_resp(2, 32'h3F800000, 4'b0000);
      expect_resp(0, 32'h40400000, 4'b0000);
      @(posedge clk);
      #2 set_req(0, 32'h40800000, 32'h40800000);
      wait_hs(7);
      @(posedge clk);
      #2;
      set_req(0, 32'h40000000, 32'h3F800000);
      set_req(2, 32'h3F000000, 32'h3F000000);
      wait_resp(8, 200);
      check("fair_grant_0", hs_log[6], 0);
      check("fair_grant_1", hs_log[7], 2);
      check("fair_grant_2", hs_log[8], 0);

      // Timeout: the adder never answers
      mode = M_NEVER;
      expect_resp(3, 32'h00000000, 4'b0001);
      @(posedge clk);
      #2 set_req(3, 32'h3F800000, 32'h3F800000);
      wait_resp(9, TIMEOUT + 30);
      check("timeout_latency", resp_cyc - go_cyc, TIMEOUT + 2);
      mode = M_NORMAL;
      expect_resp(1, 32'h40800000, 4'b0000);
      @(posedge clk);
      #2 set_req(1, 32'h40400000, 32'h3F800000);
      wait_resp(10, 50);

      // ResultReady stuck high from before Go; also a request withdrawn while busy
      mode = M_STUCK;
      @(posedge clk);
      #2 bus.AdderReady = 1'b1;
      expect_resp(2, 32'h7F800000, 4'b0100);
      @(posedge clk);
      #2 set_req(2, 32'h3F800000, 32'h3F800000);
      wait_go(12);
      @(posedge clk);
      #2 set_req(0, 32'h40000000, 32'h40000000);
      repeat (3) @(posedge clk);
      #2 bus.ReqValid[0] = 1'b0;
      repeat (8) @(negedge clk);
      check("stuck_no_resp", resp_count, 10);
      check("stuck_busy", busy, 1);
      @(posedge clk);
      #2;
      bus.AdderResult = 32'h7F800000;
      bus.AdderInf    = 1'b1;
      bus.AdderReady  = 1'b0;
      @(posedge clk);
      #2 bus.AdderReady = 1'b1;
      wait_resp(11, 20);
      repeat (5) @(negedge clk);
      check("withdrawn_no_grant", hs_log.size(), 12);
      bus.AdderReady = 1'b0;
      bus.AdderInf   = 1'b0;
      mode           = M_NORMAL;

      check("sb_empty", exp_q.size(), 0);
      check("req_ready_onehot", multi_hot, 0);
      check("go_total", go_count, 12);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
